// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, sequences IF (stall, redirect, flush) and lends imem to a program loader.
// Define FETCH_PERF_EN to add saturating perf_fetch / perf_stall / perf_redirect counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          ADDR_W   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              mem_shouldBranch,
  input  logic [31:0]       mem_branchPc,
  input  logic              load_req,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_wdata,
  output logic [31:0]       pc,
  output logic [31:0]       pc_4,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  output logic              fetch_valid,
  output logic              flush,
  output logic              load_gnt
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_redirect
`endif
);
  typedef enum logic [1:0] {BOOT, RUN, DRAIN, LOAD} state_t;
  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [31:0] pc_nx;
  logic        unused_bits;
  assign unused_bits = ^mem_branchPc[1:0];
  assign pc_4 = pc + 32'd4;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      cnt   <= cnt_nx;
    end
  // Redirect wins over both stall and a loader request; DRAIN ignores redirects.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    cnt_nx   = cnt;
    case (state)
      BOOT: begin
        state_nx = load_req ? DRAIN : RUN;
        cnt_nx   = 2'd2;
      end
      RUN:
        if (mem_shouldBranch) pc_nx = {mem_branchPc[31:2], 2'b00};
        else if (load_req) begin
          state_nx = DRAIN;
          cnt_nx   = 2'd2;
        end else if (!stall) pc_nx = pc_4;
      DRAIN:
        if (!load_req) state_nx = RUN;
        else if (cnt == 2'd0) state_nx = LOAD;
        else cnt_nx = cnt - 2'd1;
      LOAD:
        if (!load_req) begin
          state_nx = BOOT;
          pc_nx    = RESET_PC;
        end
      default: state_nx = BOOT;
    endcase
  end
  always_comb begin
    fetch_valid = state == RUN;
    load_gnt    = state == LOAD;
    flush       = mem_shouldBranch && state == RUN;
    imem_we     = load_gnt && load_we;
    imem_addr   = load_gnt ? load_addr : pc[ADDR_W+1:2];
    imem_wdata  = load_wdata;
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      perf_fetch    <= '0;
      perf_stall    <= '0;
      perf_redirect <= '0;
    end else begin
      if (fetch_valid && !stall && !(&perf_fetch)) perf_fetch <= perf_fetch + 32'd1;
      if (fetch_valid && stall && !mem_shouldBranch && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
      if (flush && !(&perf_redirect)) perf_redirect <= perf_redirect + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, corner sequences and randomized run against a behavioural model.
module tb_fetch_sequencer;
  localparam int          AW  = 8;
  localparam logic [31:0] RPC = 32'h0;
  localparam int M_BOOT = 0, M_RUN = 1, M_DRAIN = 2, M_LOAD = 3;
  logic          clock, reset_n, stall, mem_shouldBranch, load_req, load_we;
  logic [31:0]   mem_branchPc, load_wdata;
  logic [AW-1:0] load_addr;
  logic [31:0]   pc, pc_4, imem_wdata;
  logic [AW-1:0] imem_addr;
  logic          imem_we, fetch_valid, flush, load_gnt;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetch, perf_stall, perf_redirect;
`endif
  fetch_sequencer #(.RESET_PC(RPC), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .mem_shouldBranch(mem_shouldBranch),
    .mem_branchPc(mem_branchPc), .load_req(load_req), .load_we(load_we), .load_addr(load_addr),
    .load_wdata(load_wdata), .pc(pc), .pc_4(pc_4), .imem_addr(imem_addr), .imem_we(imem_we),
    .imem_wdata(imem_wdata), .fetch_valid(fetch_valid), .flush(flush), .load_gnt(load_gnt)
`ifdef FETCH_PERF_EN
    , .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_redirect(perf_redirect)
`endif
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  int checks = 0, errors = 0;
  int          m_mode, m_left;
  logic [31:0] m_pc, m_pf, m_ps, m_pr;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = M_BOOT; m_pc = RPC; m_left = 0; m_pf = 0; m_ps = 0; m_pr = 0;
  endtask
  task automatic model_check();
    chk("pc", pc, m_pc);
    chk("pc_4", pc_4, m_pc + 32'd4);
    chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_mode == M_RUN});
    chk("load_gnt", {31'b0, load_gnt}, {31'b0, m_mode == M_LOAD});
    chk("imem_we", {31'b0, imem_we}, {31'b0, m_mode == M_LOAD && load_we});
    chk("imem_addr", {24'b0, imem_addr}, {24'b0, (m_mode == M_LOAD) ? load_addr : m_pc[AW+1:2]});
    chk("flush", {31'b0, flush}, {31'b0, m_mode == M_RUN && mem_shouldBranch});
    chk("imem_wdata", imem_wdata, load_wdata);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch, m_pf);
    chk("perf_stall", perf_stall, m_ps);
    chk("perf_redirect", perf_redirect, m_pr);
`endif
  endtask
  task automatic model_update();
    case (m_mode)
      M_BOOT: if (load_req) begin m_mode = M_DRAIN; m_left = 3; end else m_mode = M_RUN;
      M_RUN: begin
        if (!stall && m_pf != 32'hFFFF_FFFF) m_pf++;
        if (stall && !mem_shouldBranch && m_ps != 32'hFFFF_FFFF) m_ps++;
        if (mem_shouldBranch && m_pr != 32'hFFFF_FFFF) m_pr++;
        if (mem_shouldBranch) m_pc = mem_branchPc & ~32'h3;
        else if (load_req) begin m_mode = M_DRAIN; m_left = 3; end
        else if (!stall) m_pc = m_pc + 32'd4;
      end
      M_DRAIN: if (!load_req) m_mode = M_RUN;
               else begin m_left--; if (m_left == 0) m_mode = M_LOAD; end
      default: if (!load_req) begin m_mode = M_BOOT; m_pc = RPC; end
    endcase
  endtask
  task automatic drive(input logic st, br, input logic [31:0] bpc, input logic lr, we,
                       input logic [AW-1:0] la, input logic [31:0] wd);
    stall = st; mem_shouldBranch = br; mem_branchPc = bpc;
    load_req = lr; load_we = we; load_addr = la; load_wdata = wd;
  endtask
  task automatic step(input logic st, br, input logic [31:0] bpc, input logic lr, we,
                      input logic [AW-1:0] la, input logic [31:0] wd);
    drive(st, br, bpc, lr, we, la, wd);
    #1 model_check();
    @(posedge clock);
    model_update();
    #1;
  endtask
  typedef struct {
    logic st, br; logic [31:0] bpc; logic lr, we; logic [AW-1:0] la; logic [31:0] wd;
    logic [31:0] e_pc; logic e_fv, e_fl, e_gnt, e_we; logic [AW-1:0] e_addr;
  } vec_t;
  function automatic vec_t v(input logic st, br, input logic [31:0] bpc, input logic lr, we,
                             input logic [AW-1:0] la, input logic [31:0] wd, input logic [31:0] epc,
                             input logic efv, efl, egnt, ewe, input logic [AW-1:0] ea);
    vec_t r;
    r.st = st; r.br = br; r.bpc = bpc; r.lr = lr; r.we = we; r.la = la; r.wd = wd;
    r.e_pc = epc; r.e_fv = efv; r.e_fl = efl; r.e_gnt = egnt; r.e_we = ewe; r.e_addr = ea;
    return r;
  endfunction
  vec_t tbl[23];
  logic lr_lvl;
  initial begin
    //             st br bpc          lr we la  wd            pc       fv fl gnt we addr
    tbl[0]  = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h00,  0, 0, 0, 0, 8'h00);
    tbl[1]  = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h00,  1, 0, 0, 0, 8'h00);
    tbl[2]  = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h04,  1, 0, 0, 0, 8'h01);
    tbl[3]  = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h08,  1, 0, 0, 0, 8'h02);
    tbl[4]  = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h0C,  1, 0, 0, 0, 8'h03);
    tbl[5]  = v(1, 0, 32'h0,        0, 0, 0,  32'h0,        32'h10,  1, 0, 0, 0, 8'h04);
    tbl[6]  = v(1, 0, 32'h0,        0, 0, 0,  32'h0,        32'h10,  1, 0, 0, 0, 8'h04);
    tbl[7]  = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h10,  1, 0, 0, 0, 8'h04);
    tbl[8]  = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h14,  1, 0, 0, 0, 8'h05);
    tbl[9]  = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h18,  1, 0, 0, 0, 8'h06);
    tbl[10] = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h1C,  1, 0, 0, 0, 8'h07);
    tbl[11] = v(1, 1, 32'h80,       0, 0, 0,  32'h0,        32'h20,  1, 1, 0, 0, 8'h08);
    tbl[12] = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h80,  1, 0, 0, 0, 8'h20);
    tbl[13] = v(0, 1, 32'h33,       0, 0, 0,  32'h0,        32'h84,  1, 1, 0, 0, 8'h21);
    tbl[14] = v(0, 0, 32'h0,        1, 0, 0,  32'h0,        32'h30,  1, 0, 0, 0, 8'h0C);
    tbl[15] = v(0, 1, 32'h100,      1, 0, 0,  32'h0,        32'h30,  0, 0, 0, 0, 8'h0C);
    tbl[16] = v(0, 0, 32'h0,        1, 0, 0,  32'h0,        32'h30,  0, 0, 0, 0, 8'h0C);
    tbl[17] = v(0, 0, 32'h0,        1, 0, 0,  32'h0,        32'h30,  0, 0, 0, 0, 8'h0C);
    tbl[18] = v(0, 0, 32'h0,        1, 1, 5,  32'hDEADBEEF, 32'h30,  0, 0, 1, 1, 8'h05);
    tbl[19] = v(0, 0, 32'h0,        0, 0, 5,  32'h0,        32'h30,  0, 0, 1, 0, 8'h05);
    tbl[20] = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h00,  0, 0, 0, 0, 8'h00);
    tbl[21] = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h00,  1, 0, 0, 0, 8'h00);
    tbl[22] = v(0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h04,  1, 0, 0, 0, 8'h01);
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_pc", pc, RPC);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_load_gnt", {31'b0, load_gnt}, 32'h0);
    @(posedge clock); #1 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].st, tbl[i].br, tbl[i].bpc, tbl[i].lr, tbl[i].we, tbl[i].la, tbl[i].wd);
      #1;
      chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("v%0d_pc_4", i), pc_4, tbl[i].e_pc + 32'd4);
      chk($sformatf("v%0d_fetch_valid", i), {31'b0, fetch_valid}, {31'b0, tbl[i].e_fv});
      chk($sformatf("v%0d_flush", i), {31'b0, flush}, {31'b0, tbl[i].e_fl});
      chk($sformatf("v%0d_load_gnt", i), {31'b0, load_gnt}, {31'b0, tbl[i].e_gnt});
      chk($sformatf("v%0d_imem_we", i), {31'b0, imem_we}, {31'b0, tbl[i].e_we});
      chk($sformatf("v%0d_imem_addr", i), {24'b0, imem_addr}, {24'b0, tbl[i].e_addr});
      chk($sformatf("v%0d_imem_wdata", i), imem_wdata, tbl[i].wd);
`ifdef FETCH_PERF_EN
      if (i == 12) begin
        chk("perf_fetch_s123", perf_fetch, 32'd8);
        chk("perf_stall_s123", perf_stall, 32'd2);
        chk("perf_redirect_s123", perf_redirect, 32'd1);
      end
`endif
      @(posedge clock);
      model_update();
      #1;
    end
    // loader gives up during DRAIN: resume at the held pc
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("drain_abort_pc", pc, 32'h8);
    chk("drain_abort_valid", {31'b0, fetch_valid}, 32'h1);
    step(0, 0, 0, 0, 0, 0, 0);
    // branch to top of address space: pc_4 wraps, imem_addr aliases
    step(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_4", pc_4, 32'h0);
    chk("wrap_imem_addr", {24'b0, imem_addr}, 32'hFF);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_next_pc", pc, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // reset asserted mid-LOAD with a write strobe active
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 9, 32'h1234_5678);
    #1;
    chk("load_gnt_pre_rst", {31'b0, load_gnt}, 32'h1);
    chk("imem_we_pre_rst", {31'b0, imem_we}, 32'h1);
    chk("pc_pre_rst", pc, 32'h8);
    #2 reset_n = 1'b0;
    #1;
    chk("midload_rst_gnt", {31'b0, load_gnt}, 32'h0);
    chk("midload_rst_we", {31'b0, imem_we}, 32'h0);
    chk("midload_rst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("midload_rst_pc", pc, RPC);
`ifdef FETCH_PERF_EN
    chk("midload_rst_perf", perf_fetch | perf_stall | perf_redirect, 32'h0);
`endif
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    model_reset();
    lr_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11) == 0) lr_lvl = ~lr_lvl;
      step($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom, lr_lvl,
           1'($urandom), AW'($urandom), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
